// File: rtl/stream_fifo.sv
// Single-clock valid/ready FIFO with a first-word-fall-through read port.
// Define FIFO_LEVEL_EN to add the level and almost_full status outputs.
module stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  input  logic             output_ready
`ifdef FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
  logic [CNT_W-1:0] count, count_next;
  logic             push, pop;

  // Readiness comes only from registered state and the reset pin, so a full
  // FIFO refuses a push even when a pop happens on the same edge.
  assign input_ready  = reset && (count != FULL_CNT);
  assign output_valid = reset && (count != '0);
  assign output_data  = mem[rd_ptr];

  assign push = input_valid  && input_ready;
  assign pop  = output_valid && output_ready;

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    // Explicit wrap keeps non-power-of-two depths correct.
    if (push) wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    if (pop)  rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // alone decide what is valid, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= input_data;
  end

`ifdef FIFO_LEVEL_EN
  assign level       = count;
  assign almost_full = (count >= ALMOST_CNT);
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a DEPTH=128 instance (a_*) and a DEPTH=4
// instance (b_*) share clock and reset.
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_in, b_in, a_od, b_od;
  logic       a_iv, a_ir, a_ov, a_or;
  logic       b_iv, b_ir, b_ov, b_or;
`ifdef FIFO_LEVEL_EN
  logic [7:0] a_level;
  logic [2:0] b_level;
  logic       a_af, b_af;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stream_fifo #(.WIDTH(8), .DEPTH(128)) dut_a (
    .clk(clk), .reset(reset),
    .input_data(a_in), .input_valid(a_iv), .input_ready(a_ir),
    .output_data(a_od), .output_valid(a_ov), .output_ready(a_or)
`ifdef FIFO_LEVEL_EN
    , .level(a_level), .almost_full(a_af)
`endif
  );

  stream_fifo #(.WIDTH(8), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset),
    .input_data(b_in), .input_valid(b_iv), .input_ready(b_ir),
    .output_data(b_od), .output_valid(b_ov), .output_ready(b_or)
`ifdef FIFO_LEVEL_EN
    , .level(b_level), .almost_full(b_af)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    a_in = '0; a_iv = 1'b0; a_or = 1'b0;
    b_in = '0; b_iv = 1'b0; b_or = 1'b0;

    // Reset and idle
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_a_ready", 32'(a_ir), 0);
      check("rst_a_valid", 32'(a_ov), 0);
      check("rst_b_ready", 32'(b_ir), 0);
    end
    reset = 1'b1;
    #1;
    check("rel_a_ready", 32'(a_ir), 1);
    check("rel_a_valid", 32'(a_ov), 0);
    check("rel_b_ready", 32'(b_ir), 1);

    // Single word with one-cycle latency
    a_in = 8'hA5; a_iv = 1'b1;
    check("single_pre_valid", 32'(a_ov), 0);
    step();
    a_iv = 1'b0;
    check("single_valid", 32'(a_ov), 1);
    check("single_data", 32'(a_od), 32'hA5);
    a_or = 1'b1;
    step();
    a_or = 1'b0;
    check("single_drained", 32'(a_ov), 0);

    // Fill DEPTH=4 to full, 5th word refused
    for (int i = 1; i <= 4; i++) begin
      b_in = 8'(i); b_iv = 1'b1;
      step();
    end
    check("full_ready", 32'(b_ir), 0);
`ifdef FIFO_LEVEL_EN
    check("full_level", 32'(b_level), 4);
    check("full_almost", 32'(b_af), 1);
`endif
    b_in = 8'h05;
    step();
    step();
    check("full_refuse_ready", 32'(b_ir), 0);
    check("full_head", 32'(b_od), 32'h01);
    b_iv = 1'b0;
    b_or = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("full_pop_valid", 32'(b_ov), 1);
      check("full_pop_data", 32'(b_od), 32'(i));
      step();
    end
    b_or = 1'b0;
    check("full_empty_valid", 32'(b_ov), 0);
    check("full_empty_ready", 32'(b_ir), 1);

    // Simultaneous push/pop at count=2, pointers wrap several times
    for (int i = 0; i < 2; i++) begin
      b_in = 8'(8'h10 + i); b_iv = 1'b1;
      step();
    end
    b_or = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_in = 8'(8'h12 + i);
      check("sim_valid", 32'(b_ov), 1);
      check("sim_ready", 32'(b_ir), 1);
      check("sim_data", 32'(b_od), 32'(8'h10 + i));
      step();
    end
    b_iv = 1'b0;
    check("sim_tail0", 32'(b_od), 32'h24);
    step();
    check("sim_tail1", 32'(b_od), 32'h25);
    step();
    b_or = 1'b0;
    check("sim_empty", 32'(b_ov), 0);

    // Full plus pop: only the pop happens on that edge
    for (int i = 0; i < 4; i++) begin
      b_in = 8'(8'h40 + i); b_iv = 1'b1;
      step();
    end
    b_in = 8'h50; b_or = 1'b1;
    check("fp_ready_full", 32'(b_ir), 0);
    step();
    b_or = 1'b0;
    check("fp_ready_after_pop", 32'(b_ir), 1);
    check("fp_head", 32'(b_od), 32'h41);
    step();
    b_iv = 1'b0;
    check("fp_full_again", 32'(b_ir), 0);
    b_or = 1'b1;
    check("fp_pop0", 32'(b_od), 32'h41);
    step();
    check("fp_pop1", 32'(b_od), 32'h42);
    step();
    check("fp_pop2", 32'(b_od), 32'h43);
    step();
    check("fp_pop3", 32'(b_od), 32'h50);
    step();
    b_or = 1'b0;
    check("fp_empty", 32'(b_ov), 0);

    // Async reset mid-stream on DEPTH=128
    a_iv = 1'b1;
    for (int i = 0; i < 50; i++) begin
      a_in = 8'(i + 1);
      step();
    end
    a_iv = 1'b0;
    check("ar_valid_before", 32'(a_ov), 1);
    check("ar_head_before", 32'(a_od), 32'h01);
    #2 reset = 1'b0;
    #1;
    check("ar_valid_async", 32'(a_ov), 0);
    check("ar_ready_async", 32'(a_ir), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("ar_rel_valid", 32'(a_ov), 0);
    check("ar_rel_ready", 32'(a_ir), 1);
    a_in = 8'h3C; a_iv = 1'b1;
    step();
    a_iv = 1'b0;
    check("ar_first_valid", 32'(a_ov), 1);
    check("ar_first_data", 32'(a_od), 32'h3C);
    a_or = 1'b1;
    step();
    a_or = 1'b0;
    check("ar_final_empty", 32'(a_ov), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Synchronous single-clock FIFO with valid/ready handshakes on both sides.
- Buffers byte-wide command/measurement traffic between host-side I/O and the Helios decoder core, in both directions.
- The read port is first-word-fall-through: the head entry is presented on output_data whenever output_valid is high.

Parameters:
- WIDTH, default 8, data word width in bits.
- DEPTH, default 128, number of storage entries; any integer >= 2 (power of two not required).

Ports:
- clk, input, 1, rising-edge clock for all state.
- reset, input, 1, asynchronous active-low reset. Low: clears the FIFO immediately. High: normal operation.
- input_data, input, WIDTH, write data.
- input_valid, input, 1, producer has a word on input_data.
- input_ready, output, 1, FIFO can accept a word this cycle.
- output_data, output, WIDTH, head-of-FIFO word.
- output_valid, output, 1, output_data holds a valid word.
- output_ready, input, 1, consumer takes the head word this cycle.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-low.
- Reset asserted (reset=0):
  - Write pointer, read pointer and occupancy count are cleared to 0 at once, without waiting for a clock edge.
  - input_ready=0 and output_valid=0 for as long as reset is low.
  - Storage contents are not cleared.
- Reset deassertion: the first edge at which a write can be accepted is the first rising clk edge after reset goes high.
- Internal state:
  - mem[0..DEPTH-1].
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits.
  - count, $clog2(DEPTH+1) bits, range 0..DEPTH.
- Push: occurs on a rising edge when input_valid && input_ready. Then mem[wr_ptr] <= input_data, and wr_ptr advances.
- Pop: occurs on a rising edge when output_valid && output_ready. Then rd_ptr advances.
- Pointer wrap: when a pointer equals DEPTH-1 and advances, it goes to 0. Wrap is explicit, so a non-power-of-two DEPTH works.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop on the same edge: unchanged, and both pointers advance.
  - neither: unchanged.
- input_ready = reset_high && (count != DEPTH). It is combinational from registered state and never depends on output_ready; a full FIFO refuses a push even if a pop happens on the same cycle.
- output_valid = reset_high && (count != 0). It is combinational from registered state.
- output_data = mem[rd_ptr], combinational read. The value is don't-care while output_valid=0.
- Latency: a word pushed at edge N appears with output_valid=1 after edge N, i.e. one cycle later. There is no bypass path, so an empty FIFO never shows input_data on output_data in the same cycle.
- Ordering: strict FIFO order. No word is ever dropped or duplicated.
- Ignored inputs:
  - input_valid while input_ready=0: ignored, no state change.
  - output_ready while output_valid=0: ignored, rd_ptr unchanged.
- Reset mid-operation: all in-flight contents are discarded. After release the FIFO reports empty, and the next word read out is the first word pushed after release.

Optional Feature:
- Macro: FIFO_LEVEL_EN.
- When defined:
  - An extra output port level, width $clog2(DEPTH+1), equals count and is 0 during reset.
  - An extra 1-bit output almost_full is high when count >= DEPTH-1.
- When undefined: neither port exists, and the ports and behaviour are exactly as listed above.

Test Plan:
- Reset and idle, WIDTH=8, DEPTH=128: hold reset=0 for 10 cycles, then release -> input_ready=0 and output_valid=0 during reset; input_ready=1 and output_valid=0 after release.
- Single word, output_ready=0: push 0xA5 -> output_valid rises exactly one cycle later with output_data=0xA5. Raise output_ready for one cycle -> output_valid=0 on the next cycle.
- Fill to full, DEPTH=4: push 0x01, 0x02, 0x03, 0x04 with output_ready=0 -> input_ready=0 after the 4th push. A 5th word 0x05 held valid is not accepted. Pop all four -> 0x01..0x04 in order, and the FIFO is empty.
- Simultaneous push/pop, DEPTH=4:
  - With count=2, drive push and pop together for 20 cycles with an incrementing pattern -> count stays 2 and the outputs emerge in order.
  - Pointers wrap several times.
- Full plus pop, DEPTH=4: with the FIFO full, input_valid=1 and output_ready=1 -> on that edge only the pop occurs and the push is refused. The push is accepted on the next cycle.
- Async reset mid-stream, DEPTH=128: push 50 words, pull reset low between clock edges -> output_valid drops immediately. After release the FIFO is empty, and the next push of 0x3C reads back first.
